// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed 32-bit Booth multiply / restoring divide
// Optional feature macro: MULTDIV_EARLY_EXIT_EN (zero-operand multiply and
// divide-by-zero finish after a single iteration cycle).
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             start_mult,
  input  logic             start_div,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t state, next_state;

  // acc holds the Booth upper half (one guard bit) or the division remainder;
  // low holds the multiplier/product low half or the dividend/quotient.
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   low;
  logic               q1;
  logic [WIDTH-1:0]   opb;
  logic               neg;
  logic               dz;
  logic [5:0]         cnt;

  logic               last_iter;
  logic               early_exit;

  logic [WIDTH:0]     mcand_x;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     mult_acc_nxt;
  logic [WIDTH-1:0]   mult_low_nxt;
  logic [2*WIDTH-1:0] product;
  logic               mult_ovf;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   div_rem_nxt;
  logic [WIDTH-1:0]   div_quo_nxt;
  logic [WIDTH-1:0]   quo_signed;
  logic               div_ovf;

  logic [WIDTH-1:0]   abs_in1;
  logic [WIDTH-1:0]   abs_in2;

  assign abs_in1 = in1[WIDTH-1] ? -in1 : in1;
  assign abs_in2 = in2[WIDTH-1] ? -in2 : in2;

  assign busy      = (state == MULT) || (state == DIV);
  assign last_iter = (cnt == LAST_ITER);

`ifdef MULTDIV_EARLY_EXIT_EN
  assign early_exit = (cnt == 6'd0) &&
                      (((state == MULT) && ((opb == '0) || (low == '0))) ||
                       ((state == DIV) && dz));
`else
  assign early_exit = 1'b0;
`endif

  // Booth step: add/subtract the sign-extended multiplicand, then arithmetic shift right
  always_comb begin
    mcand_x   = {opb[WIDTH-1], opb};
    booth_sum = acc;
    case ({low[0], q1})
      2'b01:   booth_sum = acc + mcand_x;
      2'b10:   booth_sum = acc - mcand_x;
      default: booth_sum = acc;
    endcase
    mult_acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mult_low_nxt = {booth_sum[0], low[WIDTH-1:1]};
    product      = {mult_acc_nxt[WIDTH-1:0], mult_low_nxt};
    mult_ovf     = !((&product[2*WIDTH-1:WIDTH-1]) || (~|product[2*WIDTH-1:WIDTH-1]));
  end

  // Restoring divide step on magnitudes; sign of diff tells whether the divisor fits
  always_comb begin
    shifted     = {acc[WIDTH-1:0], low[WIDTH-1]};
    diff        = shifted - {1'b0, opb};
    ge          = ~diff[WIDTH];
    div_rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    div_quo_nxt = {low[WIDTH-2:0], ge};
    quo_signed  = neg ? -div_quo_nxt : div_quo_nxt;
    div_ovf     = !neg && div_quo_nxt[WIDTH-1];
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start_mult has priority, starts only taken in IDLE/DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start_mult)      next_state = MULT;
        else if (start_div)  next_state = DIV;
        else                 next_state = IDLE;
      end
      MULT, DIV: begin
        if (last_iter || early_exit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath, iteration counter and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      low       <= '0;
      q1        <= 1'b0;
      opb       <= '0;
      neg       <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      exception <= 1'b0;
      ready     <= 1'b0;
    end else begin
      ready <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start_mult) begin
            acc <= '0;
            low <= in2;
            opb <= in1;
            q1  <= 1'b0;
            neg <= 1'b0;
            dz  <= 1'b0;
            cnt <= '0;
          end else if (start_div) begin
            acc <= '0;
            low <= abs_in1;
            opb <= abs_in2;
            q1  <= 1'b0;
            neg <= in1[WIDTH-1] ^ in2[WIDTH-1];
            dz  <= (in2 == '0);
            cnt <= '0;
          end
        end
        MULT: begin
          cnt <= cnt + 6'd1;
          acc <= mult_acc_nxt;
          low <= mult_low_nxt;
          q1  <= low[0];
          if (early_exit) begin
            result    <= '0;
            exception <= 1'b0;
          end else if (last_iter) begin
            result    <= product[WIDTH-1:0];
            exception <= mult_ovf;
          end
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          acc <= {1'b0, div_rem_nxt};
          low <= div_quo_nxt;
          if (early_exit || (last_iter && dz)) begin
            result    <= '0;
            exception <= 1'b1;
          end else if (last_iter) begin
            result    <= quo_signed;
            exception <= div_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - directed self-checking bench for multdiv_iter
module tb_multdiv_iter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        start_mult;
  logic        start_div;
  logic [31:0] result;
  logic        exception;
  logic        ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MULTDIV_EARLY_EXIT_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 33;
`endif

  multdiv_iter #(.WIDTH(32)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .in1        (in1),
    .in2        (in2),
    .start_mult (start_mult),
    .start_div  (start_div),
    .result     (result),
    .exception  (exception),
    .ready      (ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input bit is_div, input bit both,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int elat);
    int lat;
    in1        = a;
    in2        = b;
    start_mult = !is_div || both;
    start_div  = is_div || both;
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    chk({tag, "_busy"}, 36'(busy), 36'd1);
    lat = 0;
    while (!ready && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 36'(lat), 36'(elat));
    chk({tag, "_res"}, 36'(result), 36'(er));
    chk({tag, "_exc"}, 36'(exception), 36'(ee));
  endtask

  initial begin
    int lat;
    resetn     = 1'b0;
    in1        = '0;
    in2        = '0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    tick();
    tick();
    chk("rst_res",   36'(result),    36'd0);
    chk("rst_exc",   36'(exception), 36'd0);
    chk("rst_ready", 36'(ready),     36'd0);
    chk("rst_busy",  36'(busy),      36'd0);
    resetn = 1'b1;
    tick();

    // Reset in the middle of a multiply
    in1 = 32'd7;
    in2 = 32'd6;
    start_mult = 1'b1;
    tick();
    start_mult = 1'b0;
    repeat (10) tick();
    chk("midrst_busy_before", 36'(busy), 36'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_outs", 36'({result, exception, ready, busy}), 36'd0);
    tick();
    tick();
    chk("midrst_outs_held", 36'({result, exception, ready, busy}), 36'd0);
    resetn = 1'b1;
    tick();
    run_op("mul_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0, 33);

    // Signed multiply
    run_op("mul_neg3x5", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33);
    run_op("mul_ovf", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 33);
    run_op("mul_min_x_m1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);

    // Signed divide
    run_op("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_100_m3", 1'b1, 1'b0, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFDF, 1'b0, 33);
    run_op("div_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
    run_op("div_by_0", 1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 1'b1, DZ_LAT);

    // Both starts together: multiply wins
    run_op("both_3_4", 1'b0, 1'b1, 32'd3, 32'd4, 32'd12, 1'b0, 33);

    // Start while busy is dropped
    in1 = 32'd2;
    in2 = 32'd3;
    start_mult = 1'b1;
    tick();
    start_mult = 1'b0;
    repeat (5) tick();
    in1 = 32'd50;
    in2 = 32'd5;
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
    in1 = '0;
    in2 = '0;
    lat = 6;
    while (!ready && lat < 40) begin
      tick();
      lat++;
    end
    chk("busy_drop_lat", 36'(lat), 36'd33);
    chk("busy_drop_res", 36'(result), 36'd6);
    tick();
    chk("busy_drop_no_second", 36'({ready, busy}), 36'd0);

    // Back-to-back: new start taken in the cycle that precedes the ready edge
    in1 = 32'd6;
    in2 = 32'd7;
    start_mult = 1'b1;
    tick();
    start_mult = 1'b0;
    repeat (32) tick();
    chk("b2b_done_state", 36'({ready, busy}), 36'd0);
    in1 = 32'd9;
    in2 = 32'd3;
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
    chk("b2b_first", 36'({result, exception, ready, busy}), 36'({32'd42, 1'b0, 1'b1, 1'b1}));
    repeat (32) tick();
    chk("b2b_not_yet", 36'(ready), 36'd0);
    tick();
    chk("b2b_second", 36'({result, exception, ready}), 36'({32'd3, 1'b0, 1'b1}));

    // Outputs hold while operands toggle without a start
    for (int i = 0; i < 50; i++) begin
      in1 = 32'h0101_0101 * 32'(i) ^ 32'hA5A5_5A5A;
      in2 = ~in1;
      tick();
      chk("hold", 36'({result, exception, ready, busy}), 36'({32'd3, 1'b0, 1'b0, 1'b0}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
